mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB boundary of the RV32I pipeline: one-entry buffer between the memory stage and the register file write port.
- Captures ALU results and load requests, waits for the data-memory response, and sign/zero-extends load data.
- Drives exactly one register-file write per accepted instruction (RegWrite/WriteNum/WriteData).
- Applies a watchdog so a lost memory response cannot hang the pipeline.

Parameters:
- TIMEOUT, 16: max cycles spent in WAIT before forced completion; 0 disables the watchdog.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous active-low reset, sampled on posedge CLK
- in_valid  input  1  MEM stage presents an instruction
- in_ready  output  1  stage can accept; combinational, = (state != WAIT)
- in_reg_write  input  1  instruction writes rd
- in_rd  input  5  destination register
- in_is_load  input  1  instruction is a load
- in_funct3  input  3  load width/sign (RV32I encoding)
- in_addr_lo  input  2  byte address bits [1:0] of the load
- in_alu_result  input  32  result for non-load instructions
- mem_rvalid  input  1  data-memory read response valid
- mem_rdata  input  32  raw aligned 32-bit memory word
- RegWrite  output  1  register-file write enable, registered
- WriteNum  output  5  register-file write index, registered
- WriteData  output  32  register-file write data, registered
- busy  output  1  state == WAIT
- load_fault  output  1  sticky: a load timed out

Behaviour:
- Reset (RST=0 at posedge): state EMPTY; RegWrite=0, WriteNum=0, WriteData=0, load_fault=0, wait counter=0. in_ready=1, busy=0 after reset.
- States:
  - EMPTY: no instruction held.
  - WAIT: load accepted, response pending.
  - FULL: result valid; RegWrite may be asserted this cycle.
- Accept = in_valid & in_ready at posedge. Latch rd, reg_write, funct3, addr_lo, alu_result.
- Non-load accept: next state FULL. WriteData=in_alu_result visible in the cycle after acceptance (latency 1).
- Load accept: next state WAIT; counter cleared.
- WAIT, mem_rvalid=1 at posedge: next state FULL, WriteData=extend(mem_rdata). RegWrite is visible the cycle after the response.
- WAIT, no response: counter increments. When TIMEOUT!=0 and counter reaches TIMEOUT-1 with no response: next state FULL, WriteData=0, load_fault<=1.
- mem_rvalid and timeout in the same cycle: response wins; no fault.
- FULL lasts exactly one cycle. On the next edge:
  - new accept: FULL (non-load) or WAIT (load);
  - otherwise: EMPTY.
  - Back-to-back ALU ops give one write per cycle.
- RegWrite=1 only in FULL with latched reg_write=1 and rd!=0; otherwise 0.
- WriteNum/WriteData hold their last values when RegWrite=0.
- mem_rvalid outside WAIT is ignored, including responses arriving after a reset during WAIT.
- Reset during WAIT: pending load abandoned, no write issued.
- load_fault is cleared only by reset.
- Load extension, byte select = addr_lo, half select = addr_lo[1]:
  - 000 LB: sign-extend selected byte.
  - 001 LH: sign-extend selected half.
  - 010 LW: full word.
  - 100 LBU: zero-extend selected byte.
  - 101 LHU: zero-extend selected half.
  - 011/110/111: treated as LW.
  - Misaligned addr_lo[0] on halfword loads is not checked here; alignment is checked upstream.
- Counter width: $clog2(TIMEOUT+1), minimum 1.

Decomposition:
- Shared package:
  - funct3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - state encoding (ST_EMPTY, ST_WAIT, ST_FULL), 2 bits.
- Sub-module load_extend: combinational (rdata, funct3, addr_lo) -> 32-bit extended value; unit-tested separately.

Test Plan:
- ALU op, rd=5, alu=0x1234_5678 accepted at cycle N -> cycle N+1: RegWrite=1, WriteNum=5, WriteData=0x12345678; cycle N+2: RegWrite=0.
- LB, addr_lo=3, response 0x80AA_BBCC two cycles after accept -> busy=1 and in_ready=0 while waiting; cycle after response: WriteData=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080; LHU addr_lo=2 -> 0x0000_80AA.
- Three back-to-back ALU ops to rd=1,2,0 -> writes on three consecutive cycles; third has RegWrite=0 (rd=0).
- TIMEOUT=4, load with no mem_rvalid -> after 4 WAIT cycles state FULL, WriteData=0, load_fault=1 (sticky); a stray mem_rvalid afterwards has no effect.
- Response arriving on the exact timeout cycle -> data written, load_fault stays 0.
- RST low during WAIT -> all outputs 0, in_ready=1; a mem_rvalid one cycle after reset release produces no write.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline boundary: RV32I load funct3
// codes and the stage state encoding.
package mem_wb_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Selects the addressed byte/halfword of an aligned memory word and
// sign- or zero-extends it according to the RV32I load funct3.
module load_extend
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned (latch).
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Reserved encodings fall back to a full-word load.
  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB boundary: one-entry buffer that turns ALU results and load
// responses into exactly one register-file write per accepted instruction.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_alu_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        RegWrite,
  output logic [4:0]  WriteNum,
  output logic [31:0] WriteData,
  output logic        busy,
  output logic        load_fault
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_reg_write;
  logic [4:0]       r_rd;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic             r_write_en;
  logic [4:0]       r_write_num;
  logic [31:0]      r_write_data;
  logic             r_load_fault;

  logic        w_accept;
  logic        w_timeout;
  logic [31:0] w_ext_data;
  logic [1:0]  w_next_state;
  logic        w_fill;
  logic        w_fill_we;
  logic [4:0]  w_fill_num;
  logic [31:0] w_fill_data;
  logic        w_set_fault;

  load_extend u_load_extend (
    .i_rdata   (mem_rdata),
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .o_data    (w_ext_data)
  );

  assign in_ready  = (r_state != ST_WAIT);
  assign busy      = (r_state == ST_WAIT);
  assign w_accept  = in_valid & in_ready;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // w_fill marks an edge that enters FULL; a real response beats the watchdog.
  always_comb begin
    w_next_state = ST_EMPTY;
    w_fill       = 1'b0;
    w_fill_we    = 1'b0;
    w_fill_num   = r_rd;
    w_fill_data  = w_ext_data;
    w_set_fault  = 1'b0;
    if (r_state == ST_WAIT) begin
      w_next_state = ST_WAIT;
      if (mem_rvalid) begin
        w_next_state = ST_FULL;
        w_fill       = 1'b1;
        w_fill_we    = r_reg_write && (r_rd != 5'd0);
      end else if (w_timeout) begin
        w_next_state = ST_FULL;
        w_fill       = 1'b1;
        w_fill_we    = r_reg_write && (r_rd != 5'd0);
        w_fill_data  = 32'd0;
        w_set_fault  = 1'b1;
      end
    end else if (w_accept) begin
      if (in_is_load) begin
        w_next_state = ST_WAIT;
      end else begin
        w_next_state = ST_FULL;
        w_fill       = 1'b1;
        w_fill_we    = in_reg_write && (in_rd != 5'd0);
        w_fill_num   = in_rd;
        w_fill_data  = in_alu_result;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= ST_EMPTY;
      r_cnt        <= '0;
      r_reg_write  <= 1'b0;
      r_rd         <= 5'd0;
      r_funct3     <= 3'd0;
      r_addr_lo    <= 2'd0;
      r_write_en   <= 1'b0;
      r_write_num  <= 5'd0;
      r_write_data <= 32'd0;
      r_load_fault <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_write_en <= w_fill && w_fill_we;
      if (w_fill && w_fill_we) begin
        r_write_num  <= w_fill_num;
        r_write_data <= w_fill_data;
      end
      if (w_set_fault) r_load_fault <= 1'b1;
      if (r_state == ST_WAIT) begin
        if (!mem_rvalid && !w_timeout) r_cnt <= r_cnt + 1'b1;
      end else if (w_accept) begin
        r_cnt       <= '0;
        r_reg_write <= in_reg_write;
        r_rd        <= in_rd;
        r_funct3    <= in_funct3;
        r_addr_lo   <= in_addr_lo;
      end
    end
  end

  assign RegWrite   = r_write_en;
  assign WriteNum   = r_write_num;
  assign WriteData  = r_write_data;
  assign load_fault = r_load_fault;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scenario tests plus a randomized run against a transaction-level model of
// the MEM/WB stage (outstanding load with an age, one write per instruction).
module tb_mem_wb_stage;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_reg_write, in_is_load, mem_rvalid;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result, mem_rdata;
  logic        in_ready, RegWrite, busy, load_fault;
  logic [4:0]  WriteNum;
  logic [31:0] WriteData;

  logic [31:0] ext_rdata;
  logic [2:0]  ext_funct3;
  logic [1:0]  ext_addr_lo;
  logic [31:0] ext_data;

  int vectors = 0;
  int miscompares = 0;

  mem_wb_stage #(.TIMEOUT(TO)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_rd         (in_rd),
    .in_is_load    (in_is_load),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_alu_result (in_alu_result),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .RegWrite      (RegWrite),
    .WriteNum      (WriteNum),
    .WriteData     (WriteData),
    .busy          (busy),
    .load_fault    (load_fault)
  );

  load_extend u_ext (
    .i_rdata   (ext_rdata),
    .i_funct3  (ext_funct3),
    .i_addr_lo (ext_addr_lo),
    .o_data    (ext_data)
  );

  always #5 CLK = ~CLK;

  // Reference extension from the ISA rules: shift the wanted unit down, then extend.
  function automatic logic [31:0] ref_extend(logic [31:0] w, logic [2:0] f3, logic [1:0] a);
    logic [31:0] sb, sh;
    logic [7:0]  b;
    logic [15:0] h;
    sb = w >> (8 * a);
    sh = w >> (16 * a[1]);
    b  = sb[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [40:0] outs();
    return {RegWrite, WriteNum, WriteData, in_ready, busy, load_fault};
  endfunction

  function automatic logic [40:0] mk(logic rw, logic [4:0] num, logic [31:0] data,
                                      logic rdy, logic bsy, logic flt);
    return {rw, num, data, rdy, bsy, flt};
  endfunction

  function automatic string fmt(logic [40:0] v);
    return $sformatf("rw=%0b num=%0d data=%h rdy=%0b busy=%0b flt=%0b",
                     v[40], v[39:35], v[34:3], v[2], v[1], v[0]);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic ld,
                       input logic [2:0] f3, input logic [1:0] a, input logic [31:0] alu);
    in_valid      = v;
    in_reg_write  = rw;
    in_rd         = rd;
    in_is_load    = ld;
    in_funct3     = f3;
    in_addr_lo    = a;
    in_alu_result = alu;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 32'd0);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    logic [40:0] exp;
    idle();
    RST = 1'b0;
    tick();
    exp = mk(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL reset_held: got %s want %s", fmt(outs()), fmt(exp));
    end
    RST = 1'b1;
    tick();
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL reset_release: got %s want %s", fmt(outs()), fmt(exp));
    end
  endtask

  task automatic test_alu_op();
    logic [40:0] exp;
    do_reset();
    drive(1'b1, 1'b1, 5'd5, 1'b0, 3'd0, 2'd0, 32'h1234_5678);
    tick();
    idle();
    exp = mk(1'b1, 5'd5, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL alu_write: got %s want %s", fmt(outs()), fmt(exp));
    end
    tick();
    exp = mk(1'b0, 5'd5, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL alu_drop: got %s want %s", fmt(outs()), fmt(exp));
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [3] = '{3'b000, 3'b100, 3'b101};
    logic [1:0]  adrs [3] = '{2'd3, 2'd3, 2'd2};
    logic [31:0] exps [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80AA};
    logic [40:0] exp;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      drive(1'b1, 1'b1, 5'd7, 1'b1, f3s[k], adrs[k], 32'hDEAD_0000);
      tick();
      idle();
      exp = mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      for (int w = 0; w < 2; w++) begin
        vectors++;
        if (outs() !== exp) begin
          miscompares++;
          $display("FAIL load%0d_wait%0d: got %s want %s", k, w, fmt(outs()), fmt(exp));
        end
        if (w == 0) tick();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h80AA_BBCC;
      tick();
      idle();
      exp = mk(1'b1, 5'd7, exps[k], 1'b1, 1'b0, 1'b0);
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL load%0d_data: got %s want %s", k, fmt(outs()), fmt(exp));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rds [3] = '{5'd1, 5'd2, 5'd0};
    logic [31:0] alus[3] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
    logic [40:0] exp;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, rds[k], 1'b0, 3'd0, 2'd0, alus[k]);
      tick();
      if (k < 2) exp = mk(1'b1, rds[k], alus[k], 1'b1, 1'b0, 1'b0);
      else       exp = mk(1'b0, 5'd2, 32'hB2B2_0002, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL b2b_%0d: got %s want %s", k, fmt(outs()), fmt(exp));
      end
    end
    idle();
  endtask

  task automatic test_timeout();
    logic [40:0] exp;
    do_reset();
    drive(1'b1, 1'b1, 5'd9, 1'b1, 3'b010, 2'd0, 32'h0);
    tick();
    idle();
    exp = mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int w = 0; w < TO; w++) begin
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL timeout_wait%0d: got %s want %s", w, fmt(outs()), fmt(exp));
      end
      if (w < TO - 1) tick();
    end
    tick();
    exp = mk(1'b1, 5'd9, 32'd0, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL timeout_fire: got %s want %s", fmt(outs()), fmt(exp));
    end
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    tick();
    idle();
    exp = mk(1'b0, 5'd9, 32'd0, 1'b1, 1'b0, 1'b1);
    for (int w = 0; w < 2; w++) begin
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL timeout_sticky%0d: got %s want %s", w, fmt(outs()), fmt(exp));
      end
      tick();
    end
  endtask

  task automatic test_race();
    logic [40:0] exp;
    do_reset();
    drive(1'b1, 1'b1, 5'd3, 1'b1, 3'b010, 2'd0, 32'h0);
    tick();
    idle();
    for (int w = 0; w < TO - 1; w++) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    idle();
    exp = mk(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL race: got %s want %s", fmt(outs()), fmt(exp));
    end
  endtask

  task automatic test_reset_in_wait();
    logic [40:0] exp;
    do_reset();
    drive(1'b1, 1'b1, 5'd4, 1'b0, 3'd0, 2'd0, 32'h0000_0055);
    tick();
    drive(1'b1, 1'b1, 5'd6, 1'b1, 3'b010, 2'd0, 32'h0);
    tick();
    idle();
    tick();
    RST = 1'b0;
    tick();
    exp = mk(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL rst_wait: got %s want %s", fmt(outs()), fmt(exp));
    end
    RST = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1357_9BDF;
    for (int w = 0; w < 2; w++) begin
      tick();
      mem_rvalid = 1'b0;
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL rst_stray%0d: got %s want %s", w, fmt(outs()), fmt(exp));
      end
    end
  endtask

  task automatic test_extend_unit();
    logic [31:0] exp;
    for (int k = 0; k < 64; k++) begin
      ext_rdata   = $urandom;
      ext_funct3  = 3'($urandom_range(0, 7));
      ext_addr_lo = 2'($urandom_range(0, 3));
      #1;
      exp = ref_extend(ext_rdata, ext_funct3, ext_addr_lo);
      vectors++;
      if (ext_data !== exp) begin
        miscompares++;
        $display("FAIL extend f3=%0d a=%0d w=%h: got %h want %h",
                 ext_funct3, ext_addr_lo, ext_rdata, ext_data, exp);
      end
    end
  endtask

  task automatic test_random();
    logic        m_pend, m_fault, m_we, m_rw, done;
    logic [4:0]  m_num, m_rd;
    logic [31:0] m_data, d;
    logic [2:0]  m_f3;
    logic [1:0]  m_a;
    int          m_age;
    logic [40:0] exp;
    do_reset();
    m_pend = 1'b0; m_fault = 1'b0; m_we = 1'b0; m_num = 5'd0; m_data = 32'd0;
    m_rw = 1'b0; m_rd = 5'd0; m_f3 = 3'd0; m_a = 2'd0; m_age = 0;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      done = 1'b0;
      d    = 32'd0;
      m_we = 1'b0;
      if (m_pend) begin
        if (mem_rvalid) begin
          done = 1'b1;
          d    = ref_extend(mem_rdata, m_f3, m_a);
        end else if (TO != 0 && m_age == TO - 1) begin
          done    = 1'b1;
          m_fault = 1'b1;
        end else begin
          m_age++;
        end
        if (done) m_pend = 1'b0;
      end else if (in_valid) begin
        m_rw = in_reg_write;
        m_rd = in_rd;
        if (in_is_load) begin
          m_pend = 1'b1;
          m_age  = 0;
          m_f3   = in_funct3;
          m_a    = in_addr_lo;
        end else begin
          done = 1'b1;
          d    = in_alu_result;
        end
      end
      if (done && m_rw && m_rd != 5'd0) begin
        m_we   = 1'b1;
        m_num  = m_rd;
        m_data = d;
      end
      tick();
      exp = mk(m_we, m_num, m_data, !m_pend, m_pend, m_fault);
      vectors++;
      if (outs() !== exp) begin
        miscompares++;
        $display("FAIL random_c%0d: got %s want %s", c, fmt(outs()), fmt(exp));
      end
    end
    idle();
  endtask

  initial begin
    RST = 1'b0;
    idle();
    ext_rdata = 32'd0; ext_funct3 = 3'd0; ext_addr_lo = 2'd0;
    test_reset();
    test_alu_op();
    test_loads();
    test_back_to_back();
    test_timeout();
    test_race();
    test_reset_in_wait();
    test_extend_unit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
